phase_frame_sender: RTL and testbench
=====================================

// Module: phase_frame_sender
// PURPOSE
//  Transmit side of the per-channel phase bus. Accepts a full frame of NUM_CHANNELS
//  phases plus PWM enables in one ready/valid handshake, then serialises it onto
//  phase_data/phase_parse_en as one addressed word per channel, address 0 first.
//  Sits between the frame source (host/UART decoder) and the bank of phase_parser
//  instances, which each latch the word whose address matches their CHANNEL.
// PARAMETERS
//  NUM_CHANNELS  4  channels per frame; 1..256, anything else is an elaboration error
//  GAP_CYCLES    0  idle cycles inserted between consecutive words (0 = back-to-back)
// PORTS
//  clk             in   1      system clock, all logic on rising edge
//  rst             in   1      asynchronous, active-high reset
//  frame_valid     in   1      frame_phases/frame_pwm_en valid
//  frame_ready     out  1      sender idle, frame accepted on valid&&ready edge
//  frame_phases    in   8 x N  phase per channel, [i] -> address i
//  frame_pwm_en    in   1 x N  PWM enable per channel
//  phase_parse_en  out  1      word strobe, high exactly one cycle per word
//  phase_data      out  32     {8'h00, 7'b0, pwm_en, address[7:0], phase[7:0]}
//  busy            out  1      frame in flight (frame_ready inverted)
//  frame_done      out  1      one-cycle pulse after the last word's cycle
// BEHAVIOUR
//  Reset: state IDLE, frame_ready=1, busy=0, phase_parse_en=0, phase_data=32'h0,
//   frame_done=0, word index=0, latched frame cleared. No acceptance while rst=1.
//   Reset mid-frame aborts at once; remaining words are never sent.
//  States: IDLE, SEND, GAP, DONE. All outputs registered.
//  IDLE: frame_ready=1. On edge E with frame_valid=1: latch all phases/enables,
//   load word 0 onto phase_data, phase_parse_en=1, idx=0 -> SEND.
//  SEND (one cycle): word idx valid. At next edge:
//   idx==N-1 -> DONE (parse_en=0, frame_done=1);
//   else GAP_CYCLES==0 -> idx+1 word loaded, stay SEND; else -> GAP, parse_en=0.
//  GAP: GAP_CYCLES cycles, parse_en=0, phase_data holds previous word; on
//   expiry load word idx+1, parse_en=1 -> SEND.
//  DONE (one cycle): frame_done=1, parse_en=0, phase_data holds last word;
//   next edge -> IDLE, frame_done=0.
//  Timing: word i strobed in cycle starting at E + i*(GAP_CYCLES+1);
//   frame_done at E + (N-1)*(GAP_CYCLES+1) + 1; frame_ready high from the edge
//   after DONE, so frames are separated by >= 2 non-strobe cycles.
//  Word format: bits[31:24]=8'h00, [23:16]=8'h01 if enabled else 8'h00,
//   [15:8]=idx zero-extended, [7:0]=latched phase. Phase values pass unmodified,
//   8'hFF included; no arithmetic applied.
//  frame_valid while busy: ignored, no effect on the frame in flight. Input
//   changes after acceptance have no effect (frame is latched).
//  N==1: single SEND cycle then DONE. idx counter never exceeds N-1, no wrap.
// TESTING
//  T1 N=4,G=0: frame {10,20,30,40}, all en=1 -> four consecutive strobes
//     0x0001_000A,0x0001_0114,0x0001_021E,0x0001_0328; frame_done 1 cycle later.
//  T2 N=4,G=2: same frame -> strobes 3 cycles apart, parse_en=0 in gaps,
//     phase_data held; frame_done 10 cycles after accept edge.
//  T3 en={1,0,1,0}, phases=FF -> words 0x0001_00FF,0x0000_01FF,0x0001_02FF,
//     0x0000_03FF; pair with 4 phase_parser instances, each latches own value.
//  T4 frame_valid held high throughout, second frame differs -> second frame
//     starts only after DONE; first frame words unchanged by second's data.
//  T5 rst asserted during word 2 -> outputs 0, frame_ready=1 after release,
//     no further strobes, no frame_done; next frame sends from address 0.
//  T6 N=1: one strobe 0x0001_0055 for phase 0x55, then frame_done, then ready.

Source files
------------

// File: rtl/phase_frame_sender.sv
// phase_frame_sender
// Takes one complete frame of per-channel phases and PWM enables in a single
// ready/valid handshake. It then plays the frame out on the phase bus as one
// addressed 32-bit word per channel, starting at address 0. An optional run of
// idle cycles can separate consecutive words.
module phase_frame_sender #(
  parameter int NUM_CHANNELS = 4,
  parameter int GAP_CYCLES   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_valid,
  output logic                         frame_ready,
  input  logic [NUM_CHANNELS-1:0][7:0] frame_phases,
  input  logic [NUM_CHANNELS-1:0]      frame_pwm_en,
  output logic                         phase_parse_en,
  output logic [31:0]                  phase_data,
  output logic                         busy,
  output logic                         frame_done
);

  // The latched frame is padded to a power-of-two depth. This lets the word
  // index address it with exactly IDX_W bits for every channel count.
  localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int DEPTH = 1 << IDX_W;
  localparam int PH_W  = DEPTH * 8;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  generate
    if (NUM_CHANNELS < 1 || NUM_CHANNELS > 256) begin : g_bad_channels
      $error("phase_frame_sender: NUM_CHANNELS must be within 1..256");
    end
    if (GAP_CYCLES < 0) begin : g_bad_gap
      $error("phase_frame_sender: GAP_CYCLES must not be negative");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                  state_r;
  logic [IDX_W-1:0]        idx_r;
  logic [GAP_W-1:0]        gap_cnt_r;
  logic [DEPTH-1:0][7:0]   phases_r;
  logic [DEPTH-1:0]        pwm_en_r;
  logic [IDX_W-1:0]        next_idx_s;
  logic [31:0]             next_word_s;

  // Bus word layout: {8'h00, 7'b0, pwm_en, address, phase}.
  function automatic logic [31:0] make_word(input logic       en,
                                            input logic [7:0] addr,
                                            input logic [7:0] phase);
    return {8'h00, 7'h00, en, addr, phase};
  endfunction

  // Index of the following channel and its word, taken from the latched frame.
  always_comb begin
    next_idx_s  = idx_r + IDX_W'(1);
    next_word_s = make_word(pwm_en_r[next_idx_s], 8'(next_idx_s), phases_r[next_idx_s]);
  end

  // Frame sequencer: accept a frame, stream its words with optional gaps, then pulse done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      idx_r          <= '0;
      gap_cnt_r      <= '0;
      phases_r       <= '0;
      pwm_en_r       <= '0;
      frame_ready    <= 1'b1;
      busy           <= 1'b0;
      phase_parse_en <= 1'b0;
      phase_data     <= 32'h0000_0000;
      frame_done     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (frame_valid) begin
            phases_r       <= PH_W'(frame_phases);
            pwm_en_r       <= DEPTH'(frame_pwm_en);
            phase_data     <= make_word(frame_pwm_en[0], 8'h00, frame_phases[0]);
            phase_parse_en <= 1'b1;
            idx_r          <= '0;
            frame_ready    <= 1'b0;
            busy           <= 1'b1;
            state_r        <= ST_SEND;
          end else begin
            phase_parse_en <= 1'b0;
          end
        end
        ST_SEND: begin
          if (idx_r == LAST_IDX) begin
            phase_parse_en <= 1'b0;
            frame_done     <= 1'b1;
            state_r        <= ST_DONE;
          end else if (GAP_CYCLES == 0) begin
            idx_r      <= next_idx_s;
            phase_data <= next_word_s;
          end else begin
            phase_parse_en <= 1'b0;
            gap_cnt_r      <= GAP_INIT;
            state_r        <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == '0) begin
            idx_r          <= next_idx_s;
            phase_data     <= next_word_s;
            phase_parse_en <= 1'b1;
            state_r        <= ST_SEND;
          end else begin
            gap_cnt_r <= gap_cnt_r - GAP_W'(1);
          end
        end
        ST_DONE: begin
          frame_done  <= 1'b0;
          frame_ready <= 1'b1;
          busy        <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r        <= ST_IDLE;
          frame_ready    <= 1'b1;
          busy           <= 1'b0;
          phase_parse_en <= 1'b0;
          frame_done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_frame_sender.sv
// Bench for phase_frame_sender. It runs three instances side by side:
// N=4 back-to-back, N=4 with two-cycle gaps, and N=1. A monitor logs every
// strobe and done pulse with its cycle number. Each test compares that log
// with the frame timing and word format expected from the bus rules.
module tb_phase_frame_sender;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic            f_valid [3];
  logic [3:0][7:0] f_ph    [3];
  logic [3:0]      f_en    [3];
  logic            rdy     [3];
  logic            pe      [3];
  logic [31:0]     dat     [3];
  logic            bsy     [3];
  logic            dn      [3];

  rec_t sq [3][$];
  int   dq [3][$];
  rec_t exp_q [$];
  int   exp_d [$];

  always #5 clk = ~clk;

  // Cycle number; the value after edge k labels the cycle that follows edge k.
  always @(posedge clk) cyc <= cyc + 1;

  phase_frame_sender #(.NUM_CHANNELS(4), .GAP_CYCLES(0)) u_a (
    .clk(clk), .rst(rst), .frame_valid(f_valid[0]), .frame_ready(rdy[0]),
    .frame_phases(f_ph[0]), .frame_pwm_en(f_en[0]), .phase_parse_en(pe[0]),
    .phase_data(dat[0]), .busy(bsy[0]), .frame_done(dn[0]));

  phase_frame_sender #(.NUM_CHANNELS(4), .GAP_CYCLES(2)) u_b (
    .clk(clk), .rst(rst), .frame_valid(f_valid[1]), .frame_ready(rdy[1]),
    .frame_phases(f_ph[1]), .frame_pwm_en(f_en[1]), .phase_parse_en(pe[1]),
    .phase_data(dat[1]), .busy(bsy[1]), .frame_done(dn[1]));

  phase_frame_sender #(.NUM_CHANNELS(1), .GAP_CYCLES(0)) u_c (
    .clk(clk), .rst(rst), .frame_valid(f_valid[2]), .frame_ready(rdy[2]),
    .frame_phases(f_ph[2][0]), .frame_pwm_en(f_en[2][0]), .phase_parse_en(pe[2]),
    .phase_data(dat[2]), .busy(bsy[2]), .frame_done(dn[2]));

  // Bus monitor: log strobes and done pulses away from the clock edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int s = 0; s < 3; s++) begin
        if (pe[s]) sq[s].push_back('{cyc, dat[s]});
        if (dn[s]) dq[s].push_back(cyc);
      end
    end
  end

  function automatic int n_of(int s);
    return (s == 2) ? 1 : 4;
  endfunction

  function automatic int g_of(int s);
    return (s == 1) ? 2 : 0;
  endfunction

  function automatic logic [31:0] exp_word(logic en, int addr, logic [7:0] ph);
    logic [7:0] a;
    a = 8'(addr);
    return {8'h00, 7'h00, en, a, ph};
  endfunction

  // Reference: word i at accept + i*(G+1), done one cycle after the last word.
  task automatic model_frame(int s, int e, logic [3:0][7:0] p, logic [3:0] en);
    for (int i = 0; i < n_of(s); i++)
      exp_q.push_back('{e + i * (g_of(s) + 1), exp_word(en[i], i, p[i])});
    exp_d.push_back(e + (n_of(s) - 1) * (g_of(s) + 1) + 1);
  endtask

  task automatic clear_logs(int s);
    sq[s].delete();
    dq[s].delete();
    exp_q.delete();
    exp_d.delete();
  endtask

  // Wait for ready (bounded), present a frame, and return the accept cycle.
  task automatic start_frame(int s, logic [3:0][7:0] p, logic [3:0] en, output int e);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rdy[s] !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait inst=%0d got ready=%b want 1", s, rdy[s]);
    end
    f_ph[s]    = p;
    f_en[s]    = en;
    f_valid[s] = 1'b1;
    @(posedge clk);
    #1;
    e = cyc;
    checks++;
    if (bsy[s] !== 1'b1 || rdy[s] !== 1'b0) begin
      errors++;
      $display("FAIL accept_flags inst=%0d got busy=%b ready=%b want busy=1 ready=0", s, bsy[s], rdy[s]);
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      f_valid[s] = 1'b0;
      f_ph[s]    = '0;
      f_en[s]    = '0;
    end
    f_valid[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (rdy[s] !== 1'b1 || bsy[s] !== 1'b0 || pe[s] !== 1'b0 || dat[s] !== 32'h0 || dn[s] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state inst=%0d got ready=%b busy=%b pe=%b data=%h done=%b want 1 0 0 0 0",
                 s, rdy[s], bsy[s], pe[s], dat[s], dn[s]);
      end
    end
    f_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (rdy[0] !== 1'b1 || pe[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got ready=%b pe=%b want 1 0", rdy[0], pe[0]);
    end
  endtask

  task automatic test_basic();
    logic [3:0][7:0] p;
    logic [3:0]      en;
    int              e;
    clear_logs(0);
    for (int f = 0; f < 6; f++) begin
      if (f == 0) begin
        p  = {8'd40, 8'd30, 8'd20, 8'd10};
        en = 4'b1111;
      end else begin
        p  = $urandom;
        en = 4'($urandom);
      end
      start_frame(0, p, en, e);
      model_frame(0, e, p, en);
      f_valid[0] = 1'b0;
      f_ph[0]    = $urandom;
      f_en[0]    = 4'($urandom);
      repeat (n_of(0) + 2) @(posedge clk);
    end
    repeat (4) @(posedge clk);
    checks++;
    if (sq[0].size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_count got %0d strobes want %0d", sq[0].size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < sq[0].size(); i++) begin
      checks++;
      if (sq[0][i].cyc != exp_q[i].cyc || sq[0][i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL basic_word %0d got cyc %0d data %h want cyc %0d data %h",
                 i, sq[0][i].cyc, sq[0][i].data, exp_q[i].cyc, exp_q[i].data);
      end
    end
    checks++;
    if (dq[0].size() != exp_d.size()) begin
      errors++;
      $display("FAIL basic_done_count got %0d want %0d", dq[0].size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < dq[0].size(); i++) begin
      checks++;
      if (dq[0][i] != exp_d[i]) begin
        errors++;
        $display("FAIL basic_done %0d got cyc %0d want cyc %0d", i, dq[0][i], exp_d[i]);
      end
    end
  endtask

  task automatic test_gap();
    logic [3:0][7:0] p;
    logic [3:0]      en;
    int              e;
    clear_logs(1);
    for (int f = 0; f < 3; f++) begin
      if (f == 0) begin
        p  = {8'd40, 8'd30, 8'd20, 8'd10};
        en = 4'b1111;
      end else begin
        p  = $urandom;
        en = 4'($urandom);
      end
      start_frame(1, p, en, e);
      model_frame(1, e, p, en);
      f_valid[1] = 1'b0;
      f_ph[1]    = $urandom;
      for (int k = 1; k <= 2; k++) begin
        @(posedge clk);
        #1;
        checks++;
        if (pe[1] !== 1'b0 || dat[1] !== exp_word(en[0], 0, p[0])) begin
          errors++;
          $display("FAIL gap_hold cyc+%0d got pe=%b data=%h want pe=0 data=%h",
                   k, pe[1], dat[1], exp_word(en[0], 0, p[0]));
        end
      end
      repeat (12) @(posedge clk);
    end
    checks++;
    if (sq[1].size() != exp_q.size()) begin
      errors++;
      $display("FAIL gap_count got %0d strobes want %0d", sq[1].size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < sq[1].size(); i++) begin
      checks++;
      if (sq[1][i].cyc != exp_q[i].cyc || sq[1][i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL gap_word %0d got cyc %0d data %h want cyc %0d data %h",
                 i, sq[1][i].cyc, sq[1][i].data, exp_q[i].cyc, exp_q[i].data);
      end
    end
    checks++;
    if (dq[1].size() != exp_d.size()) begin
      errors++;
      $display("FAIL gap_done_count got %0d want %0d", dq[1].size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < dq[1].size(); i++) begin
      checks++;
      if (dq[1][i] != exp_d[i]) begin
        errors++;
        $display("FAIL gap_done %0d got cyc %0d want cyc %0d", i, dq[1][i], exp_d[i]);
      end
    end
  endtask

  task automatic test_enables();
    logic [3:0][7:0] p;
    logic [3:0]      en;
    logic [31:0]     latched [4];
    int              e;
    clear_logs(0);
    p  = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    en = 4'b0101;
    for (int i = 0; i < 4; i++) latched[i] = 32'hDEAD_BEEF;
    start_frame(0, p, en, e);
    model_frame(0, e, p, en);
    f_valid[0] = 1'b0;
    repeat (8) @(posedge clk);
    checks++;
    if (sq[0].size() != exp_q.size()) begin
      errors++;
      $display("FAIL enables_count got %0d strobes want %0d", sq[0].size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < sq[0].size(); i++) begin
      checks++;
      if (sq[0][i].cyc != exp_q[i].cyc || sq[0][i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL enables_word %0d got cyc %0d data %h want cyc %0d data %h",
                 i, sq[0][i].cyc, sq[0][i].data, exp_q[i].cyc, exp_q[i].data);
      end
    end
    // Four address-matched receivers, each keeping the word bearing its own address.
    foreach (sq[0][i]) begin
      if (sq[0][i].data[15:8] < 8'd4) latched[sq[0][i].data[9:8]] = sq[0][i].data;
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (latched[c][7:0] !== 8'hFF || latched[c][16] !== en[c]) begin
        errors++;
        $display("FAIL parser_latch ch %0d got phase %h en %b want phase ff en %b",
                 c, latched[c][7:0], latched[c][16], en[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0][7:0] pa, pb;
    logic [3:0]      ea, eb;
    int              e, e2;
    for (int s = 0; s < 2; s++) begin
      clear_logs(s);
      pa = $urandom;
      pb = ~pa;
      ea = 4'($urandom);
      eb = ~ea;
      start_frame(s, pa, ea, e);
      f_ph[s] = pb;
      f_en[s] = eb;
      e2 = e + (n_of(s) - 1) * (g_of(s) + 1) + 3;
      model_frame(s, e, pa, ea);
      model_frame(s, e2, pb, eb);
      repeat (e2 - e) @(posedge clk);
      #1;
      f_valid[s] = 1'b0;
      repeat (n_of(s) * (g_of(s) + 1) + 6) @(posedge clk);
      checks++;
      if (sq[s].size() != exp_q.size()) begin
        errors++;
        $display("FAIL b2b_count inst=%0d got %0d strobes want %0d", s, sq[s].size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < sq[s].size(); i++) begin
        checks++;
        if (sq[s][i].cyc != exp_q[i].cyc || sq[s][i].data !== exp_q[i].data) begin
          errors++;
          $display("FAIL b2b_word inst=%0d %0d got cyc %0d data %h want cyc %0d data %h",
                   s, i, sq[s][i].cyc, sq[s][i].data, exp_q[i].cyc, exp_q[i].data);
        end
      end
      checks++;
      if (dq[s].size() != 2 || (dq[s].size() == 2 && (dq[s][0] != exp_d[0] || dq[s][1] != exp_d[1]))) begin
        errors++;
        $display("FAIL b2b_done inst=%0d got %0d pulses want 2 at %0d and %0d",
                 s, dq[s].size(), exp_d[0], exp_d[1]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0][7:0] p;
    logic [3:0]      en;
    int              e;
    clear_logs(1);
    p  = $urandom;
    en = 4'($urandom);
    start_frame(1, p, en, e);
    f_valid[1] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (pe[1] !== 1'b1 || dat[1] !== exp_word(en[2], 2, p[2])) begin
      errors++;
      $display("FAIL rst_pre_word2 got pe=%b data=%h want pe=1 data=%h", pe[1], dat[1], exp_word(en[2], 2, p[2]));
    end
    rst = 1'b1;
    #1;
    checks++;
    if (pe[1] !== 1'b0 || dat[1] !== 32'h0 || dn[1] !== 1'b0 || rdy[1] !== 1'b1 || bsy[1] !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort got pe=%b data=%h done=%b ready=%b busy=%b want 0 0 0 1 0",
               pe[1], dat[1], dn[1], rdy[1], bsy[1]);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (sq[1].size() != 2 || dq[1].size() != 0 || rdy[1] !== 1'b1) begin
      errors++;
      $display("FAIL rst_no_resume got %0d strobes %0d done ready=%b want 2 strobes 0 done ready=1",
               sq[1].size(), dq[1].size(), rdy[1]);
    end
    clear_logs(1);
    p  = $urandom;
    en = 4'($urandom);
    start_frame(1, p, en, e);
    model_frame(1, e, p, en);
    f_valid[1] = 1'b0;
    repeat (16) @(posedge clk);
    checks++;
    if (sq[1].size() != exp_q.size()) begin
      errors++;
      $display("FAIL rst_next_count got %0d strobes want %0d", sq[1].size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < sq[1].size(); i++) begin
      checks++;
      if (sq[1][i].cyc != exp_q[i].cyc || sq[1][i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL rst_next_word %0d got cyc %0d data %h want cyc %0d data %h",
                 i, sq[1][i].cyc, sq[1][i].data, exp_q[i].cyc, exp_q[i].data);
      end
    end
  endtask

  task automatic test_single();
    logic [3:0][7:0] p;
    logic [3:0]      en;
    int              e;
    clear_logs(2);
    for (int f = 0; f < 3; f++) begin
      if (f == 0) begin
        p  = {24'h0, 8'h55};
        en = 4'b0001;
      end else begin
        p  = $urandom;
        en = 4'($urandom);
      end
      start_frame(2, p, en, e);
      model_frame(2, e, p, en);
      f_valid[2] = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (dn[2] !== 1'b1 || pe[2] !== 1'b0 || dat[2] !== exp_word(en[0], 0, p[0])) begin
        errors++;
        $display("FAIL single_done got done=%b pe=%b data=%h want 1 0 %h",
                 dn[2], pe[2], dat[2], exp_word(en[0], 0, p[0]));
      end
      @(posedge clk);
      #1;
      checks++;
      if (dn[2] !== 1'b0 || rdy[2] !== 1'b1) begin
        errors++;
        $display("FAIL single_ready got done=%b ready=%b want 0 1", dn[2], rdy[2]);
      end
    end
    checks++;
    if (sq[2].size() != exp_q.size() || dq[2].size() != exp_d.size()) begin
      errors++;
      $display("FAIL single_count got %0d strobes %0d done want %0d %0d",
               sq[2].size(), dq[2].size(), exp_q.size(), exp_d.size());
    end
    for (int i = 0; i < exp_q.size() && i < sq[2].size() && i < dq[2].size(); i++) begin
      checks++;
      if (sq[2][i].cyc != exp_q[i].cyc || sq[2][i].data !== exp_q[i].data || dq[2][i] != exp_d[i]) begin
        errors++;
        $display("FAIL single_word %0d got cyc %0d data %h done %0d want cyc %0d data %h done %0d",
                 i, sq[2][i].cyc, sq[2][i].data, dq[2][i], exp_q[i].cyc, exp_q[i].data, exp_d[i]);
      end
    end
  endtask

  // Hard stop if something stalls the sequence below.
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Test sequence.
  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_enables();
    test_back_to_back();
    test_mid_reset();
    test_single();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
